stencil_update_unit: RTL and testbench
======================================

Name: stencil_update_unit

Overview:
- Write-back side of the stencil path. After the stencil and depth tests resolve a fragment, this block reads the current stencil value for the pixel from stencil memory and applies the configured stencil operation.
- It then writes the masked result back.
- It sits between the per-fragment test stage (alpha → stencil → depth) and the shared z/stencil memory port. It processes one fragment at a time using a valid/ready handshake.

Parameters:
- ADDR_W, 20, pixel address width; covers 1280x720 = 921600 entries.
- STENCIL_W, 8, stencil value width in bits.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; asynchronous, active-high
- frag_valid_i  input  1  fragment request valid
- frag_ready_o  output  1  block can accept a fragment (IDLE only)
- frag_addr_i  input  ADDR_W  linear pixel address (y*X_RES + x)
- frag_result_i  input  2  test outcome: 0 = stencil fail, 1 = depth fail, 2 = depth pass, 3 = reserved (treated as KEEP)
- sfail_op_i  input  3  op applied on stencil fail
- dpfail_op_i  input  3  op applied on depth fail
- dppass_op_i  input  3  op applied on depth pass
- ref_val_i  input  STENCIL_W  reference value used by REPLACE
- write_mask_i  input  STENCIL_W  bitwise write mask
- mem_rd_en_o  output  1  stencil memory read strobe
- mem_rd_addr_o  output  ADDR_W  read address
- mem_rd_data_i  input  STENCIL_W  read data, valid exactly one cycle after mem_rd_en_o
- mem_wr_en_o  output  1  stencil memory write strobe
- mem_wr_addr_o  output  ADDR_W  write address
- mem_wr_data_o  output  STENCIL_W  write data
- done_o  output  1  one-cycle pulse when fragment retires
- busy_o  output  1  high in any state other than IDLE

Behaviour:

Reset:
- States and transitions are IDLE → READ → WAIT → WRITE → IDLE.
- Reset puts the block in IDLE. All outputs are 0 except frag_ready_o = 1. All internal registers are 0.
- An asynchronous reset mid-operation abandons the fragment: no write is issued and no done_o pulse occurs.

IDLE (cycle T):
- frag_ready_o = 1.
- On frag_valid_i & frag_ready_o, latch the following, then go to READ: frag_addr_i, ref_val_i, write_mask_i, and the single op selected by frag_result_i.
- Inputs are ignored after acceptance; later changes do not affect the in-flight fragment.

READ (T+1):
- mem_rd_en_o = 1, mem_rd_addr_o = latched address. Go to WAIT.

WAIT (T+2):
- Sample mem_rd_data_i as old value S.
- Compute new value N = (S & ~mask) | (R & mask) and register it. Go to WRITE.

WRITE (T+3):
- mem_wr_en_o = 1, mem_wr_addr_o = latched address, mem_wr_data_o = N, done_o = 1. Go to IDLE.

Timing:
- Earliest next acceptance is T+4. Throughput is one fragment per 4 cycles. Acceptance-to-write latency is 3 cycles.
- mem_rd_en_o, mem_wr_en_o and done_o are 0 whenever not in the states above. Address and data outputs hold their last value.

Op encoding (R = op result, S = old value; all arithmetic is STENCIL_W-bit unsigned):
- 0 KEEP: R = S
- 1 ZERO: R = 0
- 2 REPLACE: R = ref
- 3 INCR: R = S + 1, saturating at 2^STENCIL_W - 1
- 4 INCR_WRAP: R = S + 1, modulo 2^STENCIL_W
- 5 DECR: R = S - 1, saturating at 0
- 6 DECR_WRAP: R = S - 1, modulo 2^STENCIL_W
- 7 INVERT: R = ~S

Boundary and ordering rules:
- frag_result_i = 3 → KEEP.
- A write with mask 0 still writes N = S, unless the optional feature is enabled.
- Back-to-back fragments to the same address have no hazard: the write completes before the next read is issued.

Optional Feature:
- Macro: STENCIL_WRITE_ELIDE_EN.
- Defined: in WRITE, when N == S, mem_wr_en_o stays 0. done_o still pulses and timing is unchanged, so memory bandwidth is saved for KEEP, zero mask, or saturated ops.
- Undefined: every retired fragment issues a write.

Test Plan:
1. Reset, then fragment addr=0x00010, result=2, dppass_op=REPLACE, ref=0x5A, mask=0xFF, memory holds 0x00 → read at T+1, write 0x5A to 0x00010 at T+3, done_o at T+3, frag_ready_o low T+1..T+3.
2. INCR on S=0xFF and INCR_WRAP on S=0xFF, both with mask 0xFF → writes 0xFF and 0x00 respectively. DECR on S=0x00 → 0x00. DECR_WRAP on S=0x00 → 0xFF.
3. INVERT, S=0xA5, mask=0x0F → write 0xAA. REPLACE ref=0x3C, S=0xC3, mask=0xF0 → write 0x33.
4. frag_result 0/1/3 with sfail=ZERO, dpfail=INCR, dppass=REPLACE, S=0x10 → writes 0x00, 0x11, 0x10 respectively. Inputs changed after acceptance have no effect.
5. Assert rst_i in WAIT state → outputs zero immediately, no write, no done_o; the next accepted fragment behaves as in test 1.
6. KEEP op with mask 0xFF and S=0x42 → with STENCIL_WRITE_ELIDE_EN, no mem_wr_en_o but done_o pulses at T+3; without the macro, write 0x42. Continuous frag_valid_i is accepted at T, T+4, T+8.

Source files
------------

// File: rtl/stencil_update_unit.sv
// stencil_update_unit: read-modify-write of the stencil value for one resolved fragment.
// Optional macro STENCIL_WRITE_ELIDE_EN suppresses the memory write when the new value equals the old value.
module stencil_update_unit #(
    parameter int ADDR_W    = 20,
    parameter int STENCIL_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 frag_valid_i,
    output logic                 frag_ready_o,
    input  logic [ADDR_W-1:0]    frag_addr_i,
    input  logic [1:0]           frag_result_i,
    input  logic [2:0]           sfail_op_i,
    input  logic [2:0]           dpfail_op_i,
    input  logic [2:0]           dppass_op_i,
    input  logic [STENCIL_W-1:0] ref_val_i,
    input  logic [STENCIL_W-1:0] write_mask_i,
    output logic                 mem_rd_en_o,
    output logic [ADDR_W-1:0]    mem_rd_addr_o,
    input  logic [STENCIL_W-1:0] mem_rd_data_i,
    output logic                 mem_wr_en_o,
    output logic [ADDR_W-1:0]    mem_wr_addr_o,
    output logic [STENCIL_W-1:0] mem_wr_data_o,
    output logic                 done_o,
    output logic                 busy_o
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;
    localparam logic [STENCIL_W-1:0] ONE = STENCIL_W'(1);
    state_t               r_state;
    logic [2:0]           r_op;
    logic [STENCIL_W-1:0] r_ref;
    logic [STENCIL_W-1:0] r_mask;
    logic                 r_rd_en;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic                 r_wr_en;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [STENCIL_W-1:0] r_wr_data;
    logic                 r_done;
    logic [2:0]           w_sel;
    logic [STENCIL_W-1:0] w_s;
    logic [STENCIL_W-1:0] w_r;
    logic [STENCIL_W-1:0] w_n;
    always_comb begin
        w_sel = frag_result_i == 2'd0 ? sfail_op_i :
                frag_result_i == 2'd1 ? dpfail_op_i :
                frag_result_i == 2'd2 ? dppass_op_i : 3'd0;
        w_s   = mem_rd_data_i;
        w_r   = r_op == 3'd0 ? w_s :
                r_op == 3'd1 ? '0 :
                r_op == 3'd2 ? r_ref :
                r_op == 3'd3 ? (&w_s ? w_s : w_s + ONE) :
                r_op == 3'd4 ? w_s + ONE :
                r_op == 3'd5 ? (w_s == '0 ? w_s : w_s - ONE) :
                r_op == 3'd6 ? w_s - ONE : ~w_s;
        w_n   = (w_s & ~r_mask) | (w_r & r_mask);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_ref     <= '0;
            r_mask    <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (frag_valid_i) begin
                    r_op      <= w_sel;
                    r_ref     <= ref_val_i;
                    r_mask    <= write_mask_i;
                    r_rd_addr <= frag_addr_i;
                    r_rd_en   <= 1'b1;
                    r_state   <= READ;
                end
                READ: begin
                    r_rd_en <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Read data is valid in this cycle, one cycle after the strobe
`ifdef STENCIL_WRITE_ELIDE_EN
                    r_wr_en   <= w_n != w_s;
`else
                    r_wr_en   <= 1'b1;
`endif
                    r_wr_addr <= r_rd_addr;
                    r_wr_data <= w_n;
                    r_done    <= 1'b1;
                    r_state   <= WRITE;
                end
                default: begin
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
    assign frag_ready_o  = r_state == IDLE;
    assign busy_o        = r_state != IDLE;
    assign mem_rd_en_o   = r_rd_en;
    assign mem_rd_addr_o = r_rd_addr;
    assign mem_wr_en_o   = r_wr_en;
    assign mem_wr_addr_o = r_wr_addr;
    assign mem_wr_data_o = r_wr_data;
    assign done_o        = r_done;
endmodule

// File: tb/tb_stencil_update_unit.sv
// tb_stencil_update_unit: directed checks of the stencil read-modify-write unit.
module tb_stencil_update_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        frag_valid_i = 1'b0;
    logic        frag_ready_o;
    logic [19:0] frag_addr_i = '0;
    logic [1:0]  frag_result_i = '0;
    logic [2:0]  sfail_op_i = '0;
    logic [2:0]  dpfail_op_i = '0;
    logic [2:0]  dppass_op_i = '0;
    logic [7:0]  ref_val_i = '0;
    logic [7:0]  write_mask_i = '0;
    logic        mem_rd_en_o;
    logic [19:0] mem_rd_addr_o;
    logic [7:0]  mem_rd_data_i = '0;
    logic        mem_wr_en_o;
    logic [19:0] mem_wr_addr_o;
    logic [7:0]  mem_wr_data_o;
    logic        done_o;
    logic        busy_o;
    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;

    stencil_update_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .frag_valid_i(frag_valid_i), .frag_ready_o(frag_ready_o),
        .frag_addr_i(frag_addr_i), .frag_result_i(frag_result_i),
        .sfail_op_i(sfail_op_i), .dpfail_op_i(dpfail_op_i), .dppass_op_i(dppass_op_i),
        .ref_val_i(ref_val_i), .write_mask_i(write_mask_i),
        .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
        .mem_wr_en_o(mem_wr_en_o), .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
        .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory returns read data one cycle after the strobe
    always @(posedge clk_i)
        if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ready"}, 32'(frag_ready_o), 1);
        chk({tag, " busy"}, 32'(busy_o), 0);
        chk({tag, " rd_en"}, 32'(mem_rd_en_o), 0);
        chk({tag, " wr_en"}, 32'(mem_wr_en_o), 0);
        chk({tag, " done"}, 32'(done_o), 0);
        chk({tag, " rd_addr"}, 32'(mem_rd_addr_o), 0);
        chk({tag, " wr_addr"}, 32'(mem_wr_addr_o), 0);
        chk({tag, " wr_data"}, 32'(mem_wr_data_o), 0);
    endtask

    task automatic frag(input string tag, input logic [19:0] a, input logic [1:0] res,
                        input logic [2:0] sf, input logic [2:0] dpf, input logic [2:0] dpp,
                        input logic [7:0] rv, input logic [7:0] wm, input logic [7:0] s,
                        input logic [7:0] exp_n);
        bit wr = 1'b1;
`ifdef STENCIL_WRITE_ELIDE_EN
        wr = exp_n != s;
`endif
        mem[a[7:0]] = s;
        @(negedge clk_i);
        frag_valid_i = 1'b1; frag_addr_i = a; frag_result_i = res;
        sfail_op_i = sf; dpfail_op_i = dpf; dppass_op_i = dpp;
        ref_val_i = rv; write_mask_i = wm;
        chk({tag, " T ready"}, 32'(frag_ready_o), 1);
        @(posedge clk_i); #1;
        frag_valid_i = 1'b0; frag_addr_i = ~a; frag_result_i = ~res;
        sfail_op_i = ~sf; dpfail_op_i = ~dpf; dppass_op_i = ~dpp;
        ref_val_i = ~rv; write_mask_i = ~wm;
        chk({tag, " T1 rd_en"}, 32'(mem_rd_en_o), 1);
        chk({tag, " T1 rd_addr"}, 32'(mem_rd_addr_o), 32'(a));
        chk({tag, " T1 ready"}, 32'(frag_ready_o), 0);
        chk({tag, " T1 busy"}, 32'(busy_o), 1);
        @(posedge clk_i); #1;
        chk({tag, " T2 rd_en"}, 32'(mem_rd_en_o), 0);
        chk({tag, " T2 wr_en"}, 32'(mem_wr_en_o), 0);
        chk({tag, " T2 ready"}, 32'(frag_ready_o), 0);
        @(posedge clk_i); #1;
        chk({tag, " T3 wr_en"}, 32'(mem_wr_en_o), 32'(wr));
        chk({tag, " T3 done"}, 32'(done_o), 1);
        chk({tag, " T3 ready"}, 32'(frag_ready_o), 0);
        chk({tag, " T3 wr_addr"}, 32'(mem_wr_addr_o), 32'(a));
        chk({tag, " T3 wr_data"}, 32'(mem_wr_data_o), 32'(exp_n));
        @(posedge clk_i); #1;
        chk({tag, " T4 done"}, 32'(done_o), 0);
        chk({tag, " T4 wr_en"}, 32'(mem_wr_en_o), 0);
        chk({tag, " T4 ready"}, 32'(frag_ready_o), 1);
        chk({tag, " T4 busy"}, 32'(busy_o), 0);
    endtask

    initial begin
        int acc[$];
        for (int i = 0; i < 256; i++) mem[i] = '0;
        #1;
        chk_reset("reset");
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;
        chk_reset("post reset");
        frag("replace", 20'h00010, 2'd2, 3'd0, 3'd0, 3'd2, 8'h5A, 8'hFF, 8'h00, 8'h5A);
        frag("incr sat", 20'h00021, 2'd2, 3'd0, 3'd0, 3'd3, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        frag("incr wrap", 20'h00022, 2'd2, 3'd0, 3'd0, 3'd4, 8'h00, 8'hFF, 8'hFF, 8'h00);
        frag("decr sat", 20'h00023, 2'd2, 3'd0, 3'd0, 3'd5, 8'h00, 8'hFF, 8'h00, 8'h00);
        frag("decr wrap", 20'h00024, 2'd2, 3'd0, 3'd0, 3'd6, 8'h00, 8'hFF, 8'h00, 8'hFF);
        frag("invert mask", 20'h00030, 2'd2, 3'd0, 3'd0, 3'd7, 8'h00, 8'h0F, 8'hA5, 8'hAA);
        frag("replace mask", 20'h00031, 2'd2, 3'd0, 3'd0, 3'd2, 8'h3C, 8'hF0, 8'hC3, 8'h33);
        frag("sfail zero", 20'h00040, 2'd0, 3'd1, 3'd3, 3'd2, 8'h77, 8'hFF, 8'h10, 8'h00);
        frag("dpfail incr", 20'h00040, 2'd1, 3'd1, 3'd3, 3'd2, 8'h77, 8'hFF, 8'h10, 8'h11);
        frag("reserved keep", 20'h00041, 2'd3, 3'd1, 3'd3, 3'd2, 8'h77, 8'hFF, 8'h10, 8'h10);
        frag("mask zero", 20'h00042, 2'd2, 3'd0, 3'd0, 3'd2, 8'h99, 8'h00, 8'h6E, 8'h6E);
        frag("keep", 20'h00050, 2'd2, 3'd0, 3'd0, 3'd0, 8'h00, 8'hFF, 8'h42, 8'h42);
        mem[8'h60] = 8'h01;
        @(negedge clk_i);
        frag_valid_i = 1'b1; frag_addr_i = 20'h00060; frag_result_i = 2'd2;
        dppass_op_i = 3'd2; ref_val_i = 8'hEE; write_mask_i = 8'hFF;
        @(posedge clk_i); #1;
        frag_valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("abort in wait", 32'(busy_o), 1);
        rst_i = 1'b1;
        #1;
        chk_reset("abort");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("abort no write", 32'(mem_wr_en_o), 0);
            chk("abort no done", 32'(done_o), 0);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        frag("after abort", 20'h00010, 2'd2, 3'd0, 3'd0, 3'd2, 8'h5A, 8'hFF, 8'h00, 8'h5A);
        @(negedge clk_i);
        frag_valid_i = 1'b1; frag_addr_i = 20'h00070; frag_result_i = 2'd2;
        dppass_op_i = 3'd2; ref_val_i = 8'h11; write_mask_i = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            if (frag_ready_o) acc.push_back(i);
            @(negedge clk_i);
        end
        frag_valid_i = 1'b0;
        chk("stream count", 32'(acc.size()), 3);
        if (acc.size() == 3) begin
            chk("stream acc0", 32'(acc[0]), 0);
            chk("stream acc1", 32'(acc[1]), 4);
            chk("stream acc2", 32'(acc[2]), 8);
        end
        repeat (4) @(negedge clk_i);
        chk("stream idle", 32'(frag_ready_o), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
